// File: rtl/ifns_encoder_22di_seq.sv
// rtl/ifns_encoder_22di_seq.sv - greedy sequential IFNS 22-bit encoder, one weight per cycle
// Optional final-remainder self-check enabled by defining IFNS_SELFCHECK_EN.
module ifns_encoder_22di_seq #(
   parameter int DW = 22,
   parameter int CW = 31
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_code,
   output logic          chk_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   // W[1..30] are Fibonacci; W[31] jumps to F32 so the 22-bit range is covered.
   function automatic logic [22:0] weight(input int i);
      logic [22:0] a, b, t;
      a = 23'd1;
      b = 23'd1;
      if (i == 31) begin
         b = 23'd2178309;
      end else if (i <= 0) begin
         b = 23'd0;
      end else begin
         for (int k = 3; k <= i; k++) begin
            t = a + b;
            a = b;
            b = t;
         end
      end
      return b;
   endfunction

   logic [22:0] wtab [0:31];
   for (genvar g = 0; g < 32; g++) begin : g_wtab
      localparam logic [22:0] WG = weight(g);
      assign wtab[g] = WG;
   end

   state_t        state, state_nxt;
   logic [22:0]   rem, rem_nxt;
   logic [4:0]    idx, idx_nxt;
   logic [CW-1:0] code, code_nxt;
   logic [22:0]   w_cur;
   logic          take;

   assign w_cur = wtab[idx];
   assign take  = (rem >= w_cur);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rem   <= '0;
         idx   <= '0;
         code  <= '0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
         idx   <= idx_nxt;
         code  <= code_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      idx_nxt   = idx;
      code_nxt  = code;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid && in_ready) begin
               rem_nxt   = {1'b0, in_data};
               idx_nxt   = 5'd31;
               code_nxt  = '0;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            // Bits arrive MSB first (d31 down to d1), so a left shift lands d_i at bit i-1.
            code_nxt = {code[CW-2:0], take};
            if (take) begin
               rem_nxt = rem - w_cur;
            end
            idx_nxt = idx - 5'd1;
            if (idx == 5'd1) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign out_code = code;

`ifdef IFNS_SELFCHECK_EN
   logic chk_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_q <= 1'b0;
      end else if (state == BUSY && idx == 5'd1 && rem_nxt != 23'd0) begin
         chk_q <= 1'b1;
      end
   end
   assign chk_err = chk_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifns_encoder_22di_seq.sv
// tb/tb_ifns_encoder_22di_seq.sv - self-checking bench for ifns_encoder_22di_seq
module tb_ifns_encoder_22di_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [21:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [30:0] out_code;
   logic        chk_err;

   int n_assert = 0;
   int n_fail   = 0;
   int expect_out = 0;
   int seen_out   = 0;

   int          w [1:31];
   logic [21:0] q [$];
   int          cyc = 0;
   int          acc_cyc = 0;
   logic        prev_ov = 1'b0;
   logic [30:0] prev_code = '0;
   logic        post_rst = 1'b0;

   ifns_encoder_22di_seq dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
      .chk_err(chk_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint got, input longint expv);
      n_assert++;
      if (got != expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, expv, $time);
      end
   endtask

   function automatic logic [30:0] enc_model(input logic [21:0] d);
      int r;
      logic [30:0] c;
      r = int'(d);
      c = '0;
      for (int i = 31; i >= 1; i--) begin
         if (r >= w[i]) begin
            c[i-1] = 1'b1;
            r -= w[i];
         end
      end
      return c;
   endfunction

   function automatic int dec_model(input logic [30:0] c);
      int s = 0;
      for (int i = 1; i <= 31; i++) if (c[i-1]) s += w[i];
      return s;
   endfunction

   initial begin
      w[1] = 1;
      w[2] = 1;
      for (int i = 3; i <= 30; i++) w[i] = w[i-1] + w[i-2];
      w[31] = 2178309;
   end

   // Scoreboard: every accepted word must reappear once, after the fixed latency, as its codeword.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk("rst_in_ready", in_ready, 0);
         q.delete();
         post_rst = 1'b1;
         prev_ov  = 1'b0;
      end else begin
         if (post_rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_code", out_code, 0);
            chk("rst_chk_err", chk_err, 0);
            post_rst = 1'b0;
         end
         chk("in_ready", in_ready, (q.size() == 0) ? 1 : 0);
         if (q.size() == 0) begin
            chk("no_spurious_valid", out_valid, 0);
         end else if (out_valid) begin
            if (!prev_ov) chk("latency", cyc - acc_cyc, 32);
            else          chk("code_hold", out_code, prev_code);
            chk("code_model", out_code, enc_model(q[0]));
            chk("roundtrip", dec_model(out_code), q[0]);
            chk("chk_err", chk_err, 0);
         end
         prev_ov   = out_valid;
         prev_code = out_code;
         if (out_valid && out_ready && q.size() != 0) begin
            void'(q.pop_front());
            seen_out++;
         end
         if (in_valid && in_ready) begin
            q.push_back(in_data);
            acc_cyc = cyc;
         end
      end
   end

   task automatic send(input logic [21:0] d);
      int n = 0;
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = 1'b0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk("send_timeout", 1, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ~d;
   endtask

   task automatic recv(input logic [30:0] exp_code, input int stall, input string nm);
      int n = 0;
      while (!out_valid && n < 200) begin
         in_valid  = 1'($urandom % 2);
         in_data   = 22'($urandom);
         out_ready = 1'($urandom % 2);
         @(posedge clk); #1;
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (n >= 200) begin
         chk({nm, "_timeout"}, 1, 0);
      end else begin
         chk(nm, out_code, exp_code);
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({nm, "_stall_valid"}, out_valid, 1);
            chk({nm, "_stall_in_ready"}, in_ready, 0);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk({nm, "_drop_valid"}, out_valid, 0);
         expect_out++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [21:0] d;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready_low", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("reset_in_ready_high", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_code", out_code, 0);
      chk("reset_chk_err", chk_err, 0);

      chk("model_100", enc_model(22'd100), 31'h0000_0428);
      chk("model_1", enc_model(22'd1), 31'h2);
      chk("model_max", enc_model(22'h3FFFFF), 31'h7E44_9128);
      chk("model_max_sum", dec_model(31'h7E44_9128), 4194303);

      send(22'd0);       recv(31'h0, 5, "enc_0");
      send(22'd100);     recv(31'h0000_0428, 0, "enc_100");
      chk("chk_err_100", chk_err, 0);
      send(22'd1);       recv(31'h2, 1, "enc_1");
      send(22'd2178309); recv(31'h4000_0000, 0, "enc_w31");
      send(22'h3FFFFF);  recv(31'h7E44_9128, 10, "enc_max");

      // Reset in the middle of BUSY discards the word.
      send(22'd77);
      repeat (14) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_code", out_code, 0);
      chk("midrst_in_ready", in_ready, 1);
      repeat (40) begin @(posedge clk); #1; end
      chk("midrst_never_valid", out_valid, 0);
      send(22'd55);      recv(31'h200, 2, "enc_55");

      for (int k = 0; k < 1000; k++) begin
         case ($urandom % 8)
            0: d = 22'h3FFFFF;
            1: d = 22'd0;
            default: d = 22'($urandom_range(0, 22'h3FFFFF));
         endcase
         repeat ($urandom % 4) begin @(posedge clk); #1; end
         send(d);
         recv(enc_model(d), int'($urandom % 4), "rand");
      end

      repeat (3) begin @(posedge clk); #1; end
      chk("words_out", seen_out, expect_out);
      chk("queue_empty", q.size(), 0);
      chk("final_chk_err", chk_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
